// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write bypass, optional zero R0 and busy scoreboard
module regfile_sb #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS),
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_R0 = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_addr,
  output logic             busy_a,
  output logic             busy_b,
  output logic             stall,
  output logic [NREGS-1:0] busy_vec
);
  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;
  logic             fwd_a, fwd_b, zero_a, zero_b, wr_ok;
  assign wr_ok = we && !(ZERO_R0 && waddr == '0);
  always_comb begin
    busy_nxt = busy;
    if (we) busy_nxt[waddr] = 1'b0;
    if (rsv) busy_nxt[rsv_addr] = 1'b1;
    if (ZERO_R0) busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
      busy <= '0;
    end else begin
      if (wr_ok) regs[waddr] <= wdata;
      busy <= busy_nxt;
    end
  end
  assign fwd_a   = BYPASS && we && waddr == raddr_a;
  assign fwd_b   = BYPASS && we && waddr == raddr_b;
  assign zero_a  = ZERO_R0 && raddr_a == '0;
  assign zero_b  = ZERO_R0 && raddr_b == '0;
  assign rdata_a = zero_a ? '0 : fwd_a ? wdata : regs[raddr_a];
  assign rdata_b = zero_b ? '0 : fwd_b ? wdata : regs[raddr_b];
  assign busy_a  = fwd_a ? 1'b0 : busy[raddr_a];
  assign busy_b  = fwd_b ? 1'b0 : busy[raddr_b];
  assign stall   = busy_a | busy_b;
  assign busy_vec = busy;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench over default, no-bypass, zero-R0 and scaled configurations
module tb_regfile_sb;
  logic clk = 1'b0, rst, we, rsv;
  logic [1:0] waddr, raddr_a, raddr_b, rsv_addr;
  logic [7:0] wdata;
  logic [7:0] rd_a [3], rd_b [3];
  logic [3:0] bv [3];
  logic bz_a [3], bz_b [3], st [3];
  logic s_we, s_rsv, s_bz_a, s_bz_b, s_st;
  logic [3:0] s_waddr, s_raddr_a, s_raddr_b, s_rsv_addr;
  logic [15:0] s_wdata, s_rd_a, s_rd_b, s_bv;
  logic [15:0] q[$];
  logic [15:0] e;
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1'b1), .ZERO_R0(1'b0)) u0 (.clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[0]), .rdata_b(rd_b[0]), .rsv(rsv), .rsv_addr(rsv_addr),
    .busy_a(bz_a[0]), .busy_b(bz_b[0]), .stall(st[0]), .busy_vec(bv[0]));
  regfile_sb #(.BYPASS(1'b0), .ZERO_R0(1'b0)) u1 (.clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[1]), .rdata_b(rd_b[1]), .rsv(rsv), .rsv_addr(rsv_addr),
    .busy_a(bz_a[1]), .busy_b(bz_b[1]), .stall(st[1]), .busy_vec(bv[1]));
  regfile_sb #(.BYPASS(1'b1), .ZERO_R0(1'b1)) u2 (.clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[2]), .rdata_b(rd_b[2]), .rsv(rsv), .rsv_addr(rsv_addr),
    .busy_a(bz_a[2]), .busy_b(bz_b[2]), .stall(st[2]), .busy_vec(bv[2]));
  regfile_sb #(.WIDTH(16), .NREGS(16), .RESET_VAL(16'h1234)) us (.clk(clk), .rst(rst), .we(s_we), .waddr(s_waddr),
    .wdata(s_wdata), .raddr_a(s_raddr_a), .raddr_b(s_raddr_b), .rdata_a(s_rd_a), .rdata_b(s_rd_b), .rsv(s_rsv),
    .rsv_addr(s_rsv_addr), .busy_a(s_bz_a), .busy_b(s_bz_b), .stall(s_st), .busy_vec(s_bv));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; we = 1; waddr = 2; wdata = 8'hFF; rsv = 1; rsv_addr = 1;
    step();
    rst = 0; we = 0; rsv = 0;
    q.push_back(16'h0); q.push_back(16'h0);
    @(negedge clk);
    e = q.pop_front(); total++;
    if (bv[0] !== e[3:0]) $display("FAIL reset_busy_vec: got %b want %b", bv[0], e[3:0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (st[0] !== e[0]) $display("FAIL reset_stall: got %b want %b", st[0], e[0]); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      raddr_a = 2'(i);
      q.push_back(16'h0);
      #1;
      e = q.pop_front(); total++;
      if (rd_a[0] !== e[7:0]) $display("FAIL reset_reg%0d: got %h want %h", i, rd_a[0], e[7:0]); else pass_cnt++;
    end
    step();
  endtask

  task automatic test_bypass();
    raddr_a = 2; we = 1; waddr = 2; wdata = 8'hA5;
    q.push_back(16'hA5); q.push_back(16'h00);
    #1;
    e = q.pop_front(); total++;
    if (rd_a[0] !== e[7:0]) $display("FAIL bypass_same_cycle: got %h want %h", rd_a[0], e[7:0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (rd_a[1] !== e[7:0]) $display("FAIL nobypass_same_cycle: got %h want %h", rd_a[1], e[7:0]); else pass_cnt++;
    step();
    we = 0;
    q.push_back(16'hA5); q.push_back(16'hA5);
    #1;
    e = q.pop_front(); total++;
    if (rd_a[0] !== e[7:0]) $display("FAIL bypass_next_cycle: got %h want %h", rd_a[0], e[7:0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (rd_a[1] !== e[7:0]) $display("FAIL nobypass_next_cycle: got %h want %h", rd_a[1], e[7:0]); else pass_cnt++;
  endtask

  task automatic test_stall();
    rsv = 1; rsv_addr = 1;
    step();
    rsv = 0; raddr_b = 1;
    q.push_back(16'h1); q.push_back(16'h1); q.push_back(16'b0010);
    #1;
    e = q.pop_front(); total++;
    if (bz_b[0] !== e[0]) $display("FAIL stall_busy_b: got %b want %b", bz_b[0], e[0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (st[0] !== e[0]) $display("FAIL stall_stall: got %b want %b", st[0], e[0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (bv[0] !== e[3:0]) $display("FAIL stall_busy_vec: got %b want %b", bv[0], e[3:0]); else pass_cnt++;
    we = 1; waddr = 1; wdata = 8'h3C;
    q.push_back(16'h0); q.push_back(16'h3C); q.push_back(16'h1); q.push_back(16'h00);
    #1;
    e = q.pop_front(); total++;
    if (bz_b[0] !== e[0]) $display("FAIL wb_bypass_busy_b: got %b want %b", bz_b[0], e[0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (rd_b[0] !== e[7:0]) $display("FAIL wb_bypass_rdata_b: got %h want %h", rd_b[0], e[7:0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (bz_b[1] !== e[0]) $display("FAIL wb_nobypass_busy_b: got %b want %b", bz_b[1], e[0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (rd_b[1] !== e[7:0]) $display("FAIL wb_nobypass_rdata_b: got %h want %h", rd_b[1], e[7:0]); else pass_cnt++;
    step();
    we = 0;
    q.push_back(16'h0); q.push_back(16'h3C);
    #1;
    e = q.pop_front(); total++;
    if (bv[0] !== e[3:0]) $display("FAIL wb_busy_cleared: got %b want %b", bv[0], e[3:0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (rd_b[0] !== e[7:0]) $display("FAIL wb_readback: got %h want %h", rd_b[0], e[7:0]); else pass_cnt++;
  endtask

  task automatic test_set_clear();
    rsv = 1; rsv_addr = 3;
    step();
    we = 1; waddr = 3; wdata = 8'h5A;
    step();
    we = 0; rsv = 0; raddr_a = 3;
    q.push_back(16'b1000); q.push_back(16'h5A);
    #1;
    e = q.pop_front(); total++;
    if (bv[0] !== e[3:0]) $display("FAIL same_idx_set_wins: got %b want %b", bv[0], e[3:0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (rd_a[0] !== e[7:0]) $display("FAIL same_idx_data: got %h want %h", rd_a[0], e[7:0]); else pass_cnt++;
    rsv = 1; rsv_addr = 1;
    step();
    we = 1; waddr = 1; wdata = 8'h11; rsv_addr = 2;
    step();
    we = 0; rsv = 0;
    q.push_back(16'b1100);
    #1;
    e = q.pop_front(); total++;
    if (bv[0] !== e[3:0]) $display("FAIL diff_idx_set_clear: got %b want %b", bv[0], e[3:0]); else pass_cnt++;
    rsv = 1; rsv_addr = 3;
    step();
    rsv = 0; we = 1; waddr = 0; wdata = 8'h77;
    step();
    we = 0; raddr_a = 0;
    q.push_back(16'b1100); q.push_back(16'h77);
    #1;
    e = q.pop_front(); total++;
    if (bv[0] !== e[3:0]) $display("FAIL rerserve_and_nonbusy_write: got %b want %b", bv[0], e[3:0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (rd_a[0] !== e[7:0]) $display("FAIL nonbusy_write_data: got %h want %h", rd_a[0], e[7:0]); else pass_cnt++;
  endtask

  task automatic test_zero_r0();
    raddr_a = 0; we = 1; waddr = 0; wdata = 8'hFF; rsv = 1; rsv_addr = 0;
    q.push_back(16'h00); q.push_back(16'hFF);
    #1;
    e = q.pop_front(); total++;
    if (rd_a[2] !== e[7:0]) $display("FAIL zero_r0_write_cycle: got %h want %h", rd_a[2], e[7:0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (rd_a[0] !== e[7:0]) $display("FAIL r0_normal_bypass: got %h want %h", rd_a[0], e[7:0]); else pass_cnt++;
    step();
    we = 0; rsv = 0;
    q.push_back(16'h00); q.push_back(16'h0); q.push_back(16'h0); q.push_back(16'h1);
    #1;
    e = q.pop_front(); total++;
    if (rd_a[2] !== e[7:0]) $display("FAIL zero_r0_after: got %h want %h", rd_a[2], e[7:0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (bv[2][0] !== e[0]) $display("FAIL zero_r0_busy0: got %b want %b", bv[2][0], e[0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (bz_a[2] !== e[0]) $display("FAIL zero_r0_busy_a: got %b want %b", bz_a[2], e[0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (bv[0][0] !== e[0]) $display("FAIL r0_normal_busy0: got %b want %b", bv[0][0], e[0]); else pass_cnt++;
  endtask

  task automatic test_scaled();
    for (int i = 0; i < 16; i++) begin
      s_raddr_a = 4'(i);
      q.push_back(16'h1234);
      #1;
      e = q.pop_front(); total++;
      if (s_rd_a !== e) $display("FAIL scaled_reset_reg%0d: got %h want %h", i, s_rd_a, e); else pass_cnt++;
    end
    s_we = 1; s_waddr = 15; s_wdata = 16'hBEEF;
    step();
    s_we = 0; s_raddr_a = 15; s_raddr_b = 15;
    q.push_back(16'hBEEF); q.push_back(16'hBEEF);
    #1;
    e = q.pop_front(); total++;
    if (s_rd_a !== e) $display("FAIL scaled_read_a: got %h want %h", s_rd_a, e); else pass_cnt++;
    e = q.pop_front(); total++;
    if (s_rd_b !== e) $display("FAIL scaled_read_b: got %h want %h", s_rd_b, e); else pass_cnt++;
    s_rsv = 1; s_rsv_addr = 7;
    step();
    s_rsv = 0;
    q.push_back(16'h0080);
    #1;
    e = q.pop_front(); total++;
    if (s_bv !== e) $display("FAIL scaled_reserve: got %h want %h", s_bv, e); else pass_cnt++;
    rst = 1;
    step();
    rst = 0;
    q.push_back(16'h0); q.push_back(16'h0); q.push_back(16'h1234);
    #1;
    e = q.pop_front(); total++;
    if (s_bv !== e) $display("FAIL scaled_reset_mid_rsv: got %h want %h", s_bv, e); else pass_cnt++;
    e = q.pop_front(); total++;
    if (bv[0] !== e[3:0]) $display("FAIL reset_mid_rsv: got %b want %b", bv[0], e[3:0]); else pass_cnt++;
    e = q.pop_front(); total++;
    if (s_rd_a !== e) $display("FAIL scaled_reset_reg15: got %h want %h", s_rd_a, e); else pass_cnt++;
  endtask

  initial begin
    rst = 1; we = 0; rsv = 0; waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0; rsv_addr = 0;
    s_we = 0; s_rsv = 0; s_waddr = 0; s_wdata = 0; s_raddr_a = 0; s_raddr_b = 0; s_rsv_addr = 0;
    step();
    test_reset();
    test_bypass();
    test_stall();
    test_set_clear();
    test_zero_r0();
    test_scaled();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file for the next-generation 8-bit CPU datapath. Generalises register count and data width, and adds:
- an independent write address;
- optional write-to-read bypass;
- an optional hardwired-zero R0;
- a per-register busy scoreboard, so the issue stage can stall on operands whose producer has not yet written back.

It sits between decode/issue (read ports, reserve) and writeback (write port).

Parameters:
WIDTH, 8, data width in bits (>=1)
NREGS, 4, number of registers (power of two, >=2)
AW, $clog2(NREGS), address width (derived; not overridden)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
ZERO_R0, 0, 1 = register 0 reads as 0, ignores writes, never busy
RESET_VAL, 0, value loaded into every register on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
we  input  1  write enable, sampled on posedge clk
waddr  input  AW  write register index
wdata  input  WIDTH  write data
raddr_a  input  AW  read port A index
raddr_b  input  AW  read port B index
rdata_a  output  WIDTH  read data A (combinational)
rdata_b  output  WIDTH  read data B (combinational)
rsv  input  1  reserve: mark rsv_addr busy (producer issued)
rsv_addr  input  AW  register to reserve
busy_a  output  1  register raddr_a is busy
busy_b  output  1  register raddr_b is busy
stall  output  1  busy_a | busy_b
busy_vec  output  NREGS  registered busy bits, bit i = register i

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates occur on posedge clk.
- Reset (rst=1 at posedge):
  - all registers <= RESET_VAL; busy_vec <= 0;
  - rst overrides we and rsv in the same cycle;
  - reset asserted mid-operation discards all pending reservations.
- Reset value of outputs (outputs are combinational on state):
  - busy_a = busy_b = stall = 0; busy_vec = 0;
  - rdata = RESET_VAL, or 0 for index 0 when ZERO_R0=1;
  - with BYPASS=1, a concurrent we still forwards wdata (see Reads).
- Write: if we=1 (and not rst), reg[waddr] <= wdata at posedge; the new value is visible 1 cycle later via normal read.
- Reads: rdata_x = reg[raddr_x], asynchronous, zero latency.
  - BYPASS=1 and we=1 and waddr==raddr_x: rdata_x = wdata in the same cycle.
  - ZERO_R0=1 and raddr_x==0: rdata_x = 0. This overrides bypass.
- ZERO_R0=1:
  - writes to index 0 are dropped;
  - rsv to index 0 is dropped; busy_vec[0] is constant 0.
- Scoreboard, per register i:
  - set: rsv=1 and rsv_addr==i -> busy[i] <= 1;
  - clear: we=1 and waddr==i -> busy[i] <= 0;
  - set and clear on the same i in the same cycle -> busy[i] <= 1 (new producer wins);
  - set and clear on different indices -> both take effect;
  - rsv on an already-busy register -> stays 1 (no counting; one outstanding producer per register);
  - we to a non-busy register -> data written, busy stays 0.
- Busy outputs:
  - busy_x = busy[raddr_x], combinational from registered state;
  - BYPASS=1 and we=1 and waddr==raddr_x: busy_x = 0 (operand available via bypass), even if busy[raddr_x] is currently 1.
- Indices are always in range because NREGS is a power of two; no wrap logic is required.
- No X on outputs after the first reset.

Test Plan:
1. Reset: drive we=1, rsv=1 with rst=1 for one cycle -> all regs read 0x00, busy_vec=0000, stall=0; the write and reserve are ignored.
2. Write/read plus bypass (BYPASS=1): we=1, waddr=2, wdata=0xA5, raddr_a=2 -> rdata_a=0xA5 in the same cycle. Next cycle with we=0 -> rdata_a=0xA5. Repeat with BYPASS=0 -> old value 0x00 in the write cycle, 0xA5 after.
3. Scoreboard stall: rsv=1, rsv_addr=1; next cycle raddr_b=1 -> busy_b=1, stall=1, busy_vec=0010. Then we=1, waddr=1, wdata=0x3C -> with bypass, busy_b=0 and rdata_b=0x3C that cycle; next cycle busy_vec=0000.
4. Simultaneous set/clear: busy[3]=1; in one cycle drive we=1, waddr=3 and rsv=1, rsv_addr=3 -> reg3 updated, busy_vec[3] remains 1. In one cycle drive we to 1 and rsv to 2 -> busy_vec[1]=0, busy_vec[2]=1.
5. ZERO_R0=1: we=1, waddr=0, wdata=0xFF and rsv to 0 -> rdata_a(raddr_a=0)=0x00 in that cycle and after; busy_vec[0]=0.
6. Scaled config (WIDTH=16, NREGS=16, RESET_VAL=16'h1234): after reset all 16 registers read 0x1234. Write 0xBEEF to index 15, read on both ports -> 0xBEEF. Reset mid-reservation with busy[7]=1 -> busy_vec=0 next cycle.
